// File: rtl/riscv_id_stage_pkg.sv
// riscv_id_stage_pkg: shared RV32I decode constants and ALU opcode encoding
// Holds the ALU opcode enum consumed by riscv_alu, the major-opcode and
// funct3/funct7 constants, and a helper mapping funct3 to an ALU opcode.
package riscv_id_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB over ADD and SRA over SRL; it is ignored for other funct3
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: combinational I/U immediate and shift-amount extraction
// Ports:
//   instr_hi  in  20  instruction bits [31:12] (the only bits any immediate uses)
//   imm_i     out 32  sign-extended I-type immediate
//   imm_u     out 32  U-type immediate, low 12 bits zero
//   shamt     out 32  zero-extended shift amount for SLLI/SRLI/SRAI
module riscv_imm_gen (
    input  logic [31:12] instr_hi,
    output logic [31:0]  imm_i,
    output logic [31:0]  imm_u,
    output logic [31:0]  shamt
);
    assign imm_i = {{20{instr_hi[31]}}, instr_hi[31:20]};
    assign imm_u = {instr_hi, 12'b0};
    assign shamt = {27'b0, instr_hi[24:20]};
endmodule

// File: rtl/riscv_id_stage.sv
// riscv_id_stage: RV32I decode/issue stage with RAW scoreboard feeding riscv_alu
// Ports:
//   clk, rstb                      clock, asynchronous active-low reset
//   instr_valid_i/instr_ready_o    fetch handshake, instr_i/pc_i payload
//   rs1/rs2_addr_o, rs1/rs2_data_i same-cycle register file read
//   flush_i                        drop the registered and the incoming instruction
//   ex_valid_o/ex_ready_i          ALU handshake, alu_op_o/alu_a_o/alu_b_o payload
//   rd_addr_o, rd_we_o, illegal_o  destination and decode status of the registered instruction
//   wb_valid_i, wb_rd_i            writeback retirement, clears the scoreboard entry
module riscv_id_stage
    import riscv_id_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit SB_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            illegal_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i
);
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            is_op, is_imm, is_lui, is_auipc, is_sh;
    logic            legal, use1, use2, hazard, accept, handoff;
    logic [XLEN-1:0] imm_i, imm_u, shamt, d_a, d_b;
    alu_op_e         d_op;
    logic [31:0]     busy, busy_nxt;

    riscv_imm_gen u_imm (
        .instr_hi (instr_i[31:12]),
        .imm_i    (imm_i),
        .imm_u    (imm_u),
        .shamt    (shamt)
    );

    assign opc        = instr_i[6:0];
    assign f3         = instr_i[14:12];
    assign f7         = instr_i[31:25];
    assign rd         = instr_i[11:7];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    assign is_op    = opc == OPC_OP;
    assign is_imm   = opc == OPC_OPIMM;
    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign is_sh    = is_imm && (f3 == F3_SLL || f3 == F3_SR);

    // funct7 only carries meaning for R-type and immediate shifts; elsewhere it is immediate bits
    assign legal = (is_op && (f7 == F7_ZERO || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))))
                || (is_imm && (!is_sh || f7 == F7_ZERO || (f7 == F7_ALT && f3 == F3_SR)))
                || is_lui || is_auipc;
    assign use1  = legal && (is_op || is_imm);
    assign use2  = legal && is_op;

    // ADDI with imm[10]=1 sets f7[5] too, so the alternate op is only honoured where it exists
    assign d_op = use1 ? f3_to_op(f3, f7[5] && (is_op || f3 == F3_SR)) : ALU_ADD;
    assign d_a  = !legal || is_lui ? '0 : is_auipc ? pc_i : rs1_data_i;
    assign d_b  = !legal ? '0 : is_op ? rs2_data_i : is_sh ? shamt : is_imm ? imm_i : imm_u;

    // A source conflicts with a retired-pending producer or with the one sitting in EX
    function automatic logic conflict(input logic [4:0] s);
        return s != 5'd0 && (busy[s] || (ex_valid_o && rd_we_o && rd_addr_o == s));
    endfunction

    assign hazard        = SB_EN && ((use1 && conflict(rs1_addr_o)) || (use2 && conflict(rs2_addr_o)));
    assign instr_ready_o = (!ex_valid_o || ex_ready_i) && !hazard && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign handoff       = ex_valid_o && ex_ready_i;

    // Set is applied after clear so a same-cycle set of the same register wins
    always_comb begin
        busy_nxt = busy;
        if (wb_valid_i && wb_rd_i != 5'd0) busy_nxt[wb_rd_i] = 1'b0;
        if (handoff && rd_we_o) busy_nxt[rd_addr_o] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ex_valid_o <= 1'b0;
            alu_op_o   <= ALU_ADD;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            rd_addr_o  <= '0;
            rd_we_o    <= 1'b0;
            illegal_o  <= 1'b0;
            busy       <= '0;
        end else begin
            busy <= busy_nxt;
            if (flush_i) begin
                ex_valid_o <= 1'b0;
            end else if (accept) begin
                ex_valid_o <= 1'b1;
                alu_op_o   <= d_op;
                alu_a_o    <= d_a;
                alu_b_o    <= d_b;
                rd_addr_o  <= rd;
                rd_we_o    <= legal && rd != 5'd0;
                illegal_o  <= !legal;
            end else if (handoff) begin
                ex_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_riscv_id_stage.sv
// tb_riscv_id_stage: directed and randomized checks of riscv_id_stage against a decode/scoreboard model
module tb_riscv_id_stage;
    import riscv_id_stage_pkg::*;

    logic        clk = 1'b0, rstb = 1'b0;
    logic        iv = 1'b0, flush = 1'b0, er = 1'b1, wbv = 1'b0;
    logic [4:0]  wbrd = '0;
    logic [31:0] instr = '0, pc = '0;
    logic [31:0] rf [32];
    logic        ready, ex_valid, rd_we, ill;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, a, b;
    logic [3:0]  op;
    int          vecs = 0, errs = 0;

    assign rs1_data = rf[instr[19:15]];
    assign rs2_data = rf[instr[24:20]];

    always #5 clk = ~clk;

    riscv_id_stage dut (
        .clk(clk), .rstb(rstb), .instr_valid_i(iv), .instr_ready_o(ready),
        .instr_i(instr), .pc_i(pc), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .flush_i(flush),
        .ex_valid_o(ex_valid), .ex_ready_i(er), .alu_op_o(op), .alu_a_o(a), .alu_b_o(b),
        .rd_addr_o(rd_addr), .rd_we_o(rd_we), .illegal_o(ill),
        .wb_valid_i(wbv), .wb_rd_i(wbrd)
    );

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        we, u1, u2;
    } dec_t;

    logic [3:0] tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    // model state: instruction held for the ALU and registers awaiting writeback
    logic        mv;
    dec_t        md;
    logic [31:0] mbusy;

    function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] p);
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '0;
        d.ill = 1'b1;
        d.op = ALU_ADD;
        d.rd = ins[11:7];
        case (ins[6:0])
            7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                d.ill = 1'b0;
                d.op = f7 == 7'h20 ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : tbl[f3];
                d.a = rf[ins[19:15]];
                d.b = rf[ins[24:20]];
                d.u1 = 1'b1;
                d.u2 = 1'b1;
            end
            7'h13: if (f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1) begin
                d.ill = 1'b0;
                d.op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
                d.a = rf[ins[19:15]];
                d.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
                d.u1 = 1'b1;
            end
            7'h37: begin d.ill = 1'b0; d.b = {ins[31:12], 12'b0}; end
            7'h17: begin d.ill = 1'b0; d.a = p; d.b = {ins[31:12], 12'b0}; end
            default: ;
        endcase
        d.we = !d.ill && d.rd != 5'd0;
        return d;
    endfunction

    function automatic logic pending(input logic [4:0] s);
        return s != 5'd0 && (mbusy[s] || (mv && md.we && md.rd == s));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv = 1'b0; flush = 1'b0; er = 1'b1; wbv = 1'b0; wbrd = '0; pc = '0;
    endtask

    task automatic do_reset();
        idle();
        rstb = 1'b0;
        cyc();
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rstb = 1'b0;
        cyc();
        cyc();
        vecs++; if ({ex_valid, op, a, b, rd_addr, rd_we, ill} !== {1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin errs++; $display("FAIL reset_outputs got v=%b op=%0d a=%h b=%h rd=%0d we=%b ill=%b exp all zero", ex_valid, op, a, b, rd_addr, rd_we, ill); end
        rstb = 1'b1;
        cyc();
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ready); end
    endtask

    task automatic test_addi();
        do_reset();
        instr = 32'h00500093; iv = 1'b1;
        #1;
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL addi_ready got %b exp 1", ready); end
        cyc();
        iv = 1'b0;
        vecs++; if ({ex_valid, op, a, b, rd_addr, rd_we} !== {1'b1, ALU_ADD, 32'd0, 32'd5, 5'd1, 1'b1}) begin errs++; $display("FAIL addi_out got v=%b op=%0d a=%h b=%h rd=%0d we=%b exp v=1 op=0 a=0 b=5 rd=1 we=1", ex_valid, op, a, b, rd_addr, rd_we); end
    endtask

    task automatic test_r_shift();
        do_reset();
        rf[1] = 32'd10; rf[2] = 32'd3;
        instr = 32'h402081B3; iv = 1'b1;
        #1;
        vecs++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin errs++; $display("FAIL rs_addr got %0d,%0d exp 1,2", rs1_addr, rs2_addr); end
        cyc();
        instr = 32'h4030D213;
        vecs++; if ({op, a, b, rd_addr} !== {ALU_SUB, 32'd10, 32'd3, 5'd3}) begin errs++; $display("FAIL sub_out got op=%0d a=%0d b=%0d rd=%0d exp op=1 a=10 b=3 rd=3", op, a, b, rd_addr); end
        cyc();
        iv = 1'b0;
        vecs++; if ({ex_valid, op, a, b, rd_addr} !== {1'b1, ALU_SRA, 32'd10, 32'd3, 5'd4}) begin errs++; $display("FAIL srai_out got v=%b op=%0d a=%0d b=%0d rd=%0d exp v=1 op=7 a=10 b=3 rd=4", ex_valid, op, a, b, rd_addr); end
    endtask

    task automatic test_hazard();
        do_reset();
        rf[1] = 32'd10;
        instr = 32'h00500093; iv = 1'b1;
        cyc();
        instr = 32'h00108133;
        #1;
        vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL haz_ex_ready got %b exp 0", ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL haz_busy_ready[%0d] got %b exp 0", i, ready); end
        end
        wbv = 1'b1; wbrd = 5'd1;
        #1;
        vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL haz_wb_cycle_ready got %b exp 0", ready); end
        cyc();
        wbv = 1'b0;
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL haz_cleared_ready got %b exp 1", ready); end
        cyc();
        iv = 1'b0;
        vecs++; if ({ex_valid, op, a, b, rd_addr} !== {1'b1, ALU_ADD, 32'd10, 32'd10, 5'd2}) begin errs++; $display("FAIL haz_issue got v=%b op=%0d a=%0d b=%0d rd=%0d exp v=1 op=0 a=10 b=10 rd=2", ex_valid, op, a, b, rd_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        er = 1'b0;
        instr = 32'h00500093; iv = 1'b1;
        cyc();
        instr = 32'h00700293;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if ({ready, ex_valid, b, rd_addr} !== {1'b0, 1'b1, 32'd5, 5'd1}) begin errs++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b b=%0d rd=%0d exp rdy=0 v=1 b=5 rd=1", i, ready, ex_valid, b, rd_addr); end
            cyc();
        end
        er = 1'b1;
        #1;
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got %b exp 1", ready); end
        cyc();
        instr = 32'h00900313;
        vecs++; if ({ex_valid, b, rd_addr} !== {1'b1, 32'd7, 5'd5}) begin errs++; $display("FAIL b2b_first got v=%b b=%0d rd=%0d exp v=1 b=7 rd=5", ex_valid, b, rd_addr); end
        cyc();
        iv = 1'b0;
        vecs++; if ({ex_valid, b, rd_addr} !== {1'b1, 32'd9, 5'd6}) begin errs++; $display("FAIL b2b_second got v=%b b=%0d rd=%0d exp v=1 b=9 rd=6", ex_valid, b, rd_addr); end
    endtask

    task automatic test_illegal_upper();
        do_reset();
        instr = 32'hFFFFFFFF; iv = 1'b1;
        cyc();
        instr = 32'h123452B7;
        vecs++; if ({ill, rd_we, op, a, b} !== {1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0}) begin errs++; $display("FAIL illegal got ill=%b we=%b op=%0d a=%h b=%h exp ill=1 we=0 op=0 a=0 b=0", ill, rd_we, op, a, b); end
        cyc();
        instr = 32'h00001397; pc = 32'h100;
        vecs++; if ({ill, rd_we, op, a, b, rd_addr} !== {1'b0, 1'b1, ALU_ADD, 32'd0, 32'h12345000, 5'd5}) begin errs++; $display("FAIL lui got ill=%b we=%b op=%0d a=%h b=%h rd=%0d exp a=0 b=12345000 rd=5", ill, rd_we, op, a, b, rd_addr); end
        cyc();
        iv = 1'b0;
        vecs++; if ({a, b, rd_addr} !== {32'h100, 32'h1000, 5'd7}) begin errs++; $display("FAIL auipc got a=%h b=%h rd=%0d exp a=100 b=1000 rd=7", a, b, rd_addr); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        er = 1'b0;
        instr = 32'h00500093; iv = 1'b1;
        cyc();
        flush = 1'b1; instr = 32'h00700293;
        #1;
        vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b exp 0", ready); end
        cyc();
        flush = 1'b0; iv = 1'b0;
        vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b exp 0", ex_valid); end
        cyc();
        vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL flush_dropped got %b exp 0", ex_valid); end
        instr = 32'h00108133; iv = 1'b1;
        #1;
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL flush_sb_unmarked got %b exp 1", ready); end
        do_reset();
        instr = 32'h00500093; iv = 1'b1;
        cyc();
        instr = 32'h00700293;
        cyc();
        er = 1'b0; instr = 32'h00108133;
        cyc();
        vecs++; if ({ready, ex_valid} !== 2'b01) begin errs++; $display("FAIL rst_pre_stall got rdy=%b v=%b exp rdy=0 v=1", ready, ex_valid); end
        #2 rstb = 1'b0;
        #1;
        vecs++; if ({ex_valid, op, a, b, rd_addr, rd_we, ill} !== {1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin errs++; $display("FAIL rst_async got v=%b op=%0d a=%h b=%h rd=%0d we=%b ill=%b exp all zero", ex_valid, op, a, b, rd_addr, rd_we, ill); end
        #1 rstb = 1'b1; er = 1'b1;
        #1;
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL rst_sb_clear got %b exp 1", ready); end
        iv = 1'b0;
    endtask

    task automatic gen(output logic [31:0] ins);
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        r[11:7] = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        case (k)
            0, 1, 2: begin
                r[6:0] = 7'h33;
                k = $urandom_range(0, 5);
                r[31:25] = k < 3 ? 7'h00 : k < 5 ? 7'h20 : 7'h01;
            end
            3, 4, 5: begin
                r[6:0] = 7'h13;
                if (r[13:12] == 2'b01 && $urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            6: r[6:0] = 7'h37;
            7: r[6:0] = 7'h17;
            8: r[6:0] = 7'h03;
            default: ;
        endcase
        ins = r;
    endtask

    task automatic test_random();
        dec_t d;
        logic exp_rdy, acc, ho;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        do_reset();
        mv = 1'b0; md = '0; mbusy = '0;
        for (int n = 0; n < 400; n++) begin
            gen(instr);
            pc = {$urandom_range(0, 65535), 2'b00};
            iv = $urandom_range(0, 4) != 0;
            er = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 19) == 0;
            wbv = $urandom_range(0, 4) < 2;
            wbrd = 5'($urandom_range(0, 7));
            #1;
            d = ref_dec(instr, pc);
            exp_rdy = (!mv || er) && !flush && !((d.u1 && pending(instr[19:15])) || (d.u2 && pending(instr[24:20])));
            vecs++; if (ready !== exp_rdy) begin errs++; $display("FAIL rnd_ready[%0d] instr=%h got %b exp %b", n, instr, ready, exp_rdy); end
            acc = iv && exp_rdy;
            ho = mv && er;
            if (wbv && wbrd != 5'd0) mbusy[wbrd] = 1'b0;
            if (ho && md.we) mbusy[md.rd] = 1'b1;
            if (flush) mv = 1'b0;
            else if (acc) begin mv = 1'b1; md = d; end
            else if (ho) mv = 1'b0;
            cyc();
            vecs++; if (ex_valid !== mv) begin errs++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, ex_valid, mv); end
            if (mv) begin
                vecs++; if ({op, a, b, rd_addr, rd_we, ill} !== {md.op, md.a, md.b, md.rd, md.we, md.ill}) begin errs++; $display("FAIL rnd_out[%0d] got op=%0d a=%h b=%h rd=%0d we=%b ill=%b exp op=%0d a=%h b=%h rd=%0d we=%b ill=%b", n, op, a, b, rd_addr, rd_we, ill, md.op, md.a, md.b, md.rd, md.we, md.ill); end
            end
        end
        idle();
    endtask

    initial begin
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = 32'(i * 3);
        test_reset();
        test_addi();
        test_r_shift();
        test_hazard();
        test_back_to_back();
        test_illegal_upper();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
